// File: rtl/data_memory_port.sv
// Data-memory responder for the control unit: bank/address registers, banked RAM
// and a registered, valid-qualified read path back to the BUS driver.
module data_memory_port #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_BITS  = 8,
    parameter int BANK_BITS  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] in_bus,
    input  logic                  in_mbs_wr_enable,
    input  logic                  in_addr_wr_enable,
    input  logic                  in_addr_inc,
    input  logic                  in_read_enable,
    input  logic                  in_wr_enable,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_data_valid,
    output logic [BANK_BITS-1:0]  out_bank,
    output logic [ADDR_BITS-1:0]  out_addr,
    output logic                  out_error
);

    localparam int IDX_BITS = BANK_BITS + ADDR_BITS;
    localparam int DEPTH    = 1 << IDX_BITS;

    typedef enum logic {IDLE, RDATA} state_e;

    state_e                  state_q;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [BANK_BITS-1:0]    bank_q, bank_d;
    logic [ADDR_BITS-1:0]    addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   data_q;
    logic                    valid_q;
    logic                    error_q;
    logic [2:0]              n_strobes;
    logic                    illegal;
    logic                    read_go;
    logic [IDX_BITS-1:0]     idx;

    assign idx     = {bank_q, addr_q};
    assign read_go = in_read_enable && !illegal;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        n_strobes = 3'(in_mbs_wr_enable) + 3'(in_addr_wr_enable)
                  + 3'(in_read_enable)   + 3'(in_wr_enable);
        illegal   = (n_strobes > 3'd1)
                  || (in_addr_inc && (in_mbs_wr_enable || in_addr_wr_enable));
        bank_d    = bank_q;
        addr_d    = addr_q;
        if (!illegal) begin
            if (in_mbs_wr_enable)  bank_d = in_bus[BANK_BITS-1:0];
            if (in_addr_wr_enable) addr_d = in_bus[ADDR_BITS-1:0];
            // Increment wraps inside the bank; it never carries into bank_q.
            if (in_addr_inc)       addr_d = addr_q + ADDR_BITS'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bank_q  <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            bank_q  <= bank_d;
            addr_q  <= addr_d;
            error_q <= illegal;
            if (read_go) data_q <= mem[idx];
            case (state_q)
                IDLE: begin
                    valid_q <= read_go;
                    state_q <= read_go ? RDATA : IDLE;
                end
                RDATA: begin
                    valid_q <= read_go;
                    state_q <= read_go ? RDATA : IDLE;
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // NOTE: RAM contents are deliberately not reset; only the control registers are.
    always_ff @(posedge clk) begin
        if (in_wr_enable && !illegal) mem[idx] <= in_bus;
    end

    assign out_data       = data_q;
    assign out_data_valid = valid_q;
    assign out_bank       = bank_q;
    assign out_addr       = addr_q;
    assign out_error      = error_q;

endmodule
